alu_sequencer: RTL and testbench

Multi-cycle front end for the combinational ALU. Accepts one operation at a time over a valid/ready request port and drives the ALU's opcode/operand inputs from registers. Captures the ALU's result, overflow and condition outputs. Executes MUL and DIV itself with iterative shift-add and restoring-divide datapaths, because the ALU has no implementation for those opcodes. Returns every result over a valid/ready response port and keeps a sticky condition-flag register for branch logic.

---
 rtl/alu_sequencer_if.sv | 44 ++++
 rtl/alu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signal bundle for the ALU sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_data0;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_out_data;
    logic              alu_ovf;
    logic [3:0]        alu_condition;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_hi;
    logic              rsp_ovf;
    logic [3:0]        rsp_cond;
    logic              rsp_dz;
    logic              rsp_err;
    logic [3:0]        cond_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
               alu_out_data, alu_ovf, alu_condition,
        input  req_ready, alu_opcode, alu_data0, alu_data1,
               rsp_valid, rsp_data, rsp_hi, rsp_ovf, rsp_cond,
               rsp_dz, rsp_err, cond_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
               alu_out_data, alu_ovf, alu_condition,
        output req_ready, alu_opcode, alu_data0, alu_data1,
               rsp_valid, rsp_data, rsp_hi, rsp_ovf, rsp_cond,
               rsp_dz, rsp_err, cond_flags
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle front end for a combinational ALU: registers ALU inputs, runs MUL
// and DIV on internal iterative datapaths, and returns results over valid/ready.
module alu_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, RESP} state_t;

    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

    state_t              state;
    logic [5:0]          cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   shf;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem;

    logic [2*DATA_W-1:0] mul_sum;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_diff;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;

    // shf carries the multiplier (consumed LSB first) or the dividend/quotient (MSB first)
    always_comb begin
        mul_sum   = acc + (shf[0] ? mcand : '0);
        rem_shift = {rem, shf[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        if (rem_diff[DATA_W]) begin
            rem_next = rem_shift[DATA_W-1:0];
            quo_next = {shf[DATA_W-2:0], 1'b0};
        end else begin
            rem_next = rem_diff[DATA_W-1:0];
            quo_next = {shf[DATA_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mcand          <= '0;
            shf            <= '0;
            divisor        <= '0;
            rem            <= '0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_hi     <= '0;
            bus.rsp_ovf    <= 1'b0;
            bus.rsp_cond   <= '0;
            bus.rsp_dz     <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.alu_opcode <= '0;
            bus.alu_data0  <= '0;
            bus.alu_data1  <= '0;
            bus.cond_flags <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        cnt           <= '0;
                        case (bus.req_op)
                            4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                                bus.alu_opcode <= bus.req_op;
                                bus.alu_data0  <= bus.req_a;
                                bus.alu_data1  <= bus.req_b;
                                state          <= EXEC;
                            end
                            4'hB: begin
                                acc   <= '0;
                                mcand <= {{DATA_W{1'b0}}, bus.req_a};
                                shf   <= bus.req_b;
                                state <= MUL;
                            end
                            4'hC: begin
                                if (bus.req_b != '0) begin
                                    rem     <= '0;
                                    shf     <= bus.req_a;
                                    divisor <= bus.req_b;
                                    state   <= DIV;
                                end else begin
                                    bus.rsp_data  <= '1;
                                    bus.rsp_hi    <= bus.req_a;
                                    bus.rsp_ovf   <= 1'b0;
                                    bus.rsp_cond  <= '0;
                                    bus.rsp_dz    <= 1'b1;
                                    bus.rsp_err   <= 1'b0;
                                    bus.rsp_valid <= 1'b1;
                                    state         <= RESP;
                                end
                            end
                            default: begin
                                bus.rsp_data  <= '0;
                                bus.rsp_hi    <= '0;
                                bus.rsp_ovf   <= 1'b0;
                                bus.rsp_cond  <= '0;
                                bus.rsp_dz    <= 1'b0;
                                bus.rsp_err   <= 1'b1;
                                bus.rsp_valid <= 1'b1;
                                state         <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    bus.rsp_data <= bus.alu_out_data;
                    bus.rsp_hi   <= '0;
                    bus.rsp_ovf  <= bus.alu_ovf;
                    bus.rsp_dz   <= 1'b0;
                    bus.rsp_err  <= 1'b0;
                    if (bus.alu_opcode == OP_SUB) begin
                        bus.rsp_cond   <= bus.alu_condition;
                        bus.cond_flags <= bus.alu_condition;
                    end else begin
                        bus.rsp_cond <= '0;
                    end
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                MUL: begin
                    acc   <= mul_sum;
                    mcand <= mcand << 1;
                    shf   <= shf >> 1;
                    cnt   <= cnt + 6'd1;
                    if (cnt == LAST_ITER) begin
                        bus.rsp_data  <= mul_sum[DATA_W-1:0];
                        bus.rsp_hi    <= mul_sum[2*DATA_W-1:DATA_W];
                        bus.rsp_ovf   <= |mul_sum[2*DATA_W-1:DATA_W];
                        bus.rsp_cond  <= '0;
                        bus.rsp_dz    <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    shf <= quo_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_ITER) begin
                        bus.rsp_data  <= quo_next;
                        bus.rsp_hi    <= rem_next;
                        bus.rsp_ovf   <= 1'b0;
                        bus.rsp_cond  <= '0;
                        bus.rsp_dz    <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model
// attached to the sequencer's ALU port.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    alu_sequencer_if #(.DATA_W(32)) bus ();

    alu_sequencer #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] d0, d1, alu_res;
    logic        alu_v;

    // Reference combinational ALU; condition is driven for every opcode so the
    // sequencer's gating of rsp_cond to SUB is observable.
    always_comb begin
        d0      = bus.alu_data0;
        d1      = bus.alu_data1;
        alu_res = '0;
        alu_v   = 1'b0;
        case (bus.alu_opcode)
            4'h0: alu_res = d0;
            4'h2: begin
                alu_res = d0 + d1;
                alu_v   = (d0[31] == d1[31]) && (alu_res[31] != d0[31]);
            end
            4'h3: begin
                alu_res = d0 - d1;
                alu_v   = (d0[31] != d1[31]) && (alu_res[31] != d0[31]);
            end
            4'h4: alu_res = d0 & d1;
            4'h5: alu_res = d0 | d1;
            4'h6: alu_res = ~(d0 | d1);
            4'h7: alu_res = d0 ^ d1;
            4'h8: alu_res = d0 << d1[4:0];
            4'h9: alu_res = d0 >> d1[4:0];
            4'hA: alu_res = $signed(d0) >>> d1[4:0];
            default: alu_res = '0;
        endcase
        bus.alu_out_data  = alu_res;
        bus.alu_ovf       = alu_v;
        bus.alu_condition = {d0 == d1, d0 != d1, $signed(d0) > $signed(d1), $signed(d0) < $signed(d1)};
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, then waits (bounded) for rsp_valid; lat counts the
    // cycle after the acceptance edge as 1. Inputs are scrambled after acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int latency);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h2;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'h1234_5678;
        latency = 1;
        while (!bus.rsp_valid && latency < 100) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checkOutput("req_ready_after_hs", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        $display("[TB] start");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        checkOutput("rst_rsp_hi", 64'(bus.rsp_hi), 64'd0);
        checkOutput("rst_flags_misc", 64'({bus.rsp_cond, bus.rsp_ovf, bus.rsp_dz, bus.rsp_err}), 64'd0);
        checkOutput("rst_alu_in", 64'({bus.alu_opcode, bus.alu_data0, bus.alu_data1}), 64'd0);
        checkOutput("rst_cond_flags", 64'(bus.cond_flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        checkOutput("add_lat", 64'(lat), 64'd2);
        checkOutput("add_data", 64'(bus.rsp_data), 64'h8000_0000);
        checkOutput("add_ovf", 64'(bus.rsp_ovf), 64'd1);
        checkOutput("add_cond", 64'(bus.rsp_cond), 64'd0);
        checkOutput("add_hi", 64'(bus.rsp_hi), 64'd0);
        checkOutput("add_flags", 64'(bus.cond_flags), 64'd0);
        checkOutput("add_alu_opcode", 64'(bus.alu_opcode), 64'h2);
        handshake();

        applyStimulus(4'h3, 32'd5, 32'd5, lat);
        checkOutput("sub_eq_data", 64'(bus.rsp_data), 64'd0);
        checkOutput("sub_eq_cond", 64'(bus.rsp_cond), 64'b1000);
        checkOutput("sub_eq_flags", 64'(bus.cond_flags), 64'b1000);
        handshake();

        applyStimulus(4'h3, 32'd3, 32'd7, lat);
        checkOutput("sub_lt_data", 64'(bus.rsp_data), 64'hFFFF_FFFC);
        checkOutput("sub_lt_cond", 64'(bus.rsp_cond), 64'b0101);
        checkOutput("sub_lt_flags", 64'(bus.cond_flags), 64'b0101);
        handshake();

        applyStimulus(4'h4, 32'h0000_F0F0, 32'h0000_FF00, lat);
        checkOutput("and_data", 64'(bus.rsp_data), 64'h0000_F000);
        checkOutput("and_cond", 64'(bus.rsp_cond), 64'd0);
        checkOutput("and_flags", 64'(bus.cond_flags), 64'b0101);
        handshake();

        applyStimulus(4'hA, 32'h8000_0000, 32'd4, lat);
        checkOutput("sra_data", 64'(bus.rsp_data), 64'hF800_0000);
        handshake();

        applyStimulus(4'h0, 32'h1234_5678, 32'hFFFF_FFFF, lat);
        checkOutput("out_data", 64'(bus.rsp_data), 64'h1234_5678);
        handshake();

        applyStimulus(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checkOutput("mul_big_lat", 64'(lat), 64'd33);
        checkOutput("mul_big_lo", 64'(bus.rsp_data), 64'h0000_0001);
        checkOutput("mul_big_hi", 64'(bus.rsp_hi), 64'hFFFF_FFFE);
        checkOutput("mul_big_ovf", 64'(bus.rsp_ovf), 64'd1);
        checkOutput("mul_alu_hold", 64'({bus.alu_opcode, bus.alu_data0}), 64'({4'h0, 32'h1234_5678}));
        handshake();

        applyStimulus(4'hB, 32'd3, 32'd4, lat);
        checkOutput("mul_small_lo", 64'(bus.rsp_data), 64'd12);
        checkOutput("mul_small_hi", 64'(bus.rsp_hi), 64'd0);
        checkOutput("mul_small_ovf", 64'(bus.rsp_ovf), 64'd0);
        handshake();

        applyStimulus(4'hC, 32'd100, 32'd7, lat);
        checkOutput("div_lat", 64'(lat), 64'd33);
        checkOutput("div_quo", 64'(bus.rsp_data), 64'd14);
        checkOutput("div_rem", 64'(bus.rsp_hi), 64'd2);
        checkOutput("div_dz_ovf", 64'({bus.rsp_dz, bus.rsp_ovf}), 64'd0);
        handshake();

        applyStimulus(4'hC, 32'd9, 32'd0, lat);
        checkOutput("dz_lat", 64'(lat), 64'd1);
        checkOutput("dz_data", 64'(bus.rsp_data), 64'hFFFF_FFFF);
        checkOutput("dz_hi", 64'(bus.rsp_hi), 64'd9);
        checkOutput("dz_flag", 64'(bus.rsp_dz), 64'd1);
        handshake();

        applyStimulus(4'h8, 32'd1, 32'd31, lat);
        checkOutput("sll_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_data", 64'(bus.rsp_data), 64'h8000_0000);
            checkOutput("bp_valid_ready", 64'({bus.rsp_valid, bus.req_ready}), 64'b10);
            @(posedge clk); #1;
        end
        handshake();

        // Reset in the middle of a multiply: no response may survive it.
        bus.req_op    = 4'hB;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd1000;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid_ready", 64'({bus.rsp_valid, bus.req_ready}), 64'b01);
        checkOutput("midrst_data_hi", 64'({bus.rsp_data, bus.rsp_hi}), 64'd0);
        checkOutput("midrst_cond_flags", 64'(bus.cond_flags), 64'd0);
        checkOutput("midrst_alu_in", 64'({bus.alu_opcode, bus.alu_data0, bus.alu_data1}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midrst_no_rsp", 64'({bus.rsp_valid, bus.req_ready}), 64'b01);

        applyStimulus(4'hD, 32'hAAAA_AAAA, 32'h5555_5555, lat);
        checkOutput("ill_lat", 64'(lat), 64'd1);
        checkOutput("ill_err", 64'(bus.rsp_err), 64'd1);
        checkOutput("ill_data_hi", 64'({bus.rsp_data, bus.rsp_hi}), 64'd0);
        checkOutput("ill_flags", 64'(bus.cond_flags), 64'd0);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
